// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD refresh controller.
// Optional INIT sequence guarded by LCD_REFRESH_INIT_SEQ_EN.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;
  localparam logic [7:0] LCD_ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD1,
    ST_DATA1,
    ST_CMD2,
    ST_DATA2,
    ST_DONE
`ifdef LCD_REFRESH_INIT_SEQ_EN
    , ST_INIT
`endif
  } lcd_state_e;

`ifdef LCD_REFRESH_INIT_SEQ_EN
  localparam logic [1:0] LCD_INIT_LAST = 2'd3;

  // Function set 8-bit/2-line, display on,
  // entry mode increment, clear display.
  function automatic logic [7:0] lcd_init_cmd(
    input logic [1:0] i
  );
    logic [7:0] c;
    c = 8'h38;
    unique case (i)
      2'd0: c = 8'h38;
      2'd1: c = 8'h0C;
      2'd2: c = 8'h06;
      2'd3: c = 8'h01;
      default: c = 8'h38;
    endcase
    return c;
  endfunction
`endif

endpackage

// File: rtl/refresh_tick_gen.sv
// Free-running refresh counter, one-cycle tick every REFRESH_CYCLES.
// Ports: i_clk, i_rst_n (sync, active-low), o_tick.
module refresh_tick_gen #(
  parameter int unsigned REFRESH_CYCLES = 5_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int unsigned CW = $clog2(REFRESH_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign o_tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (o_tick) cnt_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Sequences two snapshotted text lines into a byte-wide LCD bus.
// Ports: i_clk, i_rst_n, i_line1/2, i_update, o_lcd_valid/rs/data,
// i_lcd_ready, o_busy, o_frame_done. Option: LCD_REFRESH_INIT_SEQ_EN.
module lcd_refresh_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 5_000_000,
  parameter int unsigned COLS = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [COLS*8-1:0] i_line1,
  input  logic [COLS*8-1:0] i_line2,
  input  logic            i_update,
  output logic            o_lcd_valid,
  output logic            o_lcd_rs,
  output logic [7:0]      o_lcd_data,
  input  logic            i_lcd_ready,
  output logic            o_busy,
  output logic            o_frame_done
);

  localparam int unsigned IDX_W = $clog2(COLS);
  localparam int unsigned LW = COLS * 8;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COLS - 1);

  lcd_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic pend_q, pend_d;
  logic [LW-1:0] snap1_q, snap1_d;
  logic [LW-1:0] snap2_q, snap2_d;
  logic valid_q, valid_d;
  logic rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
`ifdef LCD_REFRESH_INIT_SEQ_EN
  logic init_done_q, init_done_d;
  logic [1:0] iidx_q, iidx_d;
`endif

  logic tick;
  logic accept;
  logic trig;

  refresh_tick_gen #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .o_tick (tick)
  );

  assign accept = valid_q & i_lcd_ready;
  assign trig   = tick | i_update | pend_q;

  // Column 0 lives in the top byte of the packed line.
  function automatic logic [7:0] col_of(
    input logic [LW-1:0] s,
    input logic [IDX_W-1:0] i
  );
    logic [7:0] b;
    b = LCD_ASCII_SPACE;
    for (int c = 0; c < COLS; c++) begin
      if (i == IDX_W'(c)) b = s[(COLS-1-c)*8 +: 8];
    end
    return b;
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      snap1_q <= '0;
      snap2_q <= '0;
      valid_q <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LCD_REFRESH_INIT_SEQ_EN
      init_done_q <= 1'b0;
      iidx_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      snap1_q <= snap1_d;
      snap2_q <= snap2_d;
      valid_q <= valid_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef LCD_REFRESH_INIT_SEQ_EN
      init_done_q <= init_done_d;
      iidx_q      <= iidx_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    snap1_d = snap1_q;
    snap2_d = snap2_q;
`ifdef LCD_REFRESH_INIT_SEQ_EN
    init_done_d = init_done_q;
    iidx_d      = iidx_q;
`endif
    // Any trigger outside IDLE is remembered once.
    if (state_q != ST_IDLE) pend_d = pend_q | tick | i_update;
    unique case (state_q)
      ST_IDLE: begin
`ifdef LCD_REFRESH_INIT_SEQ_EN
        if (!init_done_q) begin
          state_d = ST_INIT;
          iidx_d  = '0;
          pend_d  = pend_q | tick | i_update;
        end else
`endif
        if (trig) begin
          state_d = ST_CMD1;
          pend_d  = 1'b0;
          snap1_d = i_line1;
          snap2_d = i_line2;
        end
      end
      ST_CMD1: begin
        if (accept) begin
          state_d = ST_DATA1;
          idx_d   = '0;
        end
      end
      ST_DATA1: begin
        if (accept) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_CMD2;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_CMD2: begin
        if (accept) begin
          state_d = ST_DATA2;
          idx_d   = '0;
        end
      end
      ST_DATA2: begin
        if (accept) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
`ifdef LCD_REFRESH_INIT_SEQ_EN
      ST_INIT: begin
        if (accept) begin
          if (iidx_q == LCD_INIT_LAST) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end else begin
            iidx_d = iidx_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register
  // alongside it and hold while the state holds.
  always_comb begin
    valid_d = 1'b0;
    rs_d    = 1'b0;
    data_d  = 8'h00;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    unique case (state_d)
      ST_CMD1: begin
        valid_d = 1'b1;
        data_d  = LCD_CMD_LINE1;
      end
      ST_DATA1: begin
        valid_d = 1'b1;
        rs_d    = 1'b1;
        data_d  = col_of(snap1_q, idx_d);
      end
      ST_CMD2: begin
        valid_d = 1'b1;
        data_d  = LCD_CMD_LINE2;
      end
      ST_DATA2: begin
        valid_d = 1'b1;
        rs_d    = 1'b1;
        data_d  = col_of(snap2_q, idx_d);
      end
`ifdef LCD_REFRESH_INIT_SEQ_EN
      ST_INIT: begin
        valid_d = 1'b1;
        data_d  = lcd_init_cmd(iidx_d);
      end
`endif
      default: ;
    endcase
  end

  assign o_lcd_valid  = valid_q;
  assign o_lcd_rs     = rs_q;
  assign o_lcd_data   = data_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Directed bench for lcd_refresh_ctrl with REFRESH_CYCLES=100.
// Honours LCD_REFRESH_INIT_SEQ_EN when defined.
module tb_lcd_refresh_ctrl;

  localparam logic [127:0] L1_25 = "TEMP=25 C       ";
  localparam logic [127:0] L1_30 = "TEMP=30 C       ";
  localparam logic [127:0] L2_60 = "HUM =60 %       ";
`ifdef LCD_REFRESH_INIT_SEQ_EN
  localparam int OFF = 4;
`else
  localparam int OFF = 0;
`endif

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic [127:0] i_line1 = L1_25;
  logic [127:0] i_line2 = L2_60;
  logic i_update = 1'b0;
  logic i_lcd_ready = 1'b1;
  logic o_lcd_valid, o_lcd_rs, o_busy, o_frame_done;
  logic [7:0] o_lcd_data;

  int checks = 0;
  int failures = 0;
  int en = -1;
  int done_cnt = 0;
  logic [8:0] mq[$];

  lcd_refresh_ctrl #(
    .REFRESH_CYCLES(100),
    .COLS(16)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_line1(i_line1),
    .i_line2(i_line2),
    .i_update(i_update),
    .o_lcd_valid(o_lcd_valid),
    .o_lcd_rs(o_lcd_rs),
    .o_lcd_data(o_lcd_data),
    .i_lcd_ready(i_lcd_ready),
    .o_busy(o_busy),
    .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (!i_rst_n) en <= -1;
    else          en <= en + 1;
  end

  always @(negedge i_clk) begin
    if (o_lcd_valid && i_lcd_ready)
      mq.push_back({o_lcd_rs, o_lcd_data});
    if (o_frame_done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [8:0] exp_byte(
    input logic [127:0] l1,
    input logic [127:0] l2,
    input int i
  );
    if (i == 0) return 9'h080;
    if (i < 17) return {1'b1, l1[(16-i)*8 +: 8]};
    if (i == 17) return 9'h0C0;
    return {1'b1, l2[(33-i)*8 +: 8]};
  endfunction

  function automatic int frame_bad(
    input logic [127:0] l1,
    input logic [127:0] l2,
    input int off
  );
    for (int i = 0; i < 34; i++) begin
      if (mq.size() <= off + i) return i;
      if (mq[off+i] !== exp_byte(l1, l2, i)) return i;
    end
    return -1;
  endfunction

  task automatic wait_en(input int n);
    for (int k = 0; k < 2000 && en != n; k++)
      @(negedge i_clk);
  endtask

  task automatic pulse_update;
    i_update = 1'b1;
    @(negedge i_clk);
    i_update = 1'b0;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_lcd_valid, o_lcd_rs, o_lcd_data} !== 10'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h exp=0",
               {o_lcd_valid, o_lcd_rs, o_lcd_data});
    end
    checks++;
    if ({o_busy, o_frame_done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_status got=%b exp=00",
               {o_busy, o_frame_done});
    end
    i_rst_n = 1'b1;
  endtask

  task automatic test_tick_frame;
    int base, d0, n, bad;
    base = mq.size();
    d0 = done_cnt;
    wait_en(98);
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL pre_tick_idle got=%b exp=0", o_busy);
    end
    @(negedge i_clk);
    checks++;
    if ({o_busy, o_lcd_valid, o_lcd_rs, o_lcd_data}
        !== 11'b110_1000_0000) begin
      failures++;
      $display("FAIL tick_start got=%b exp=11010000000",
               {o_busy, o_lcd_valid, o_lcd_rs, o_lcd_data});
    end
    n = 0;
    while (o_busy && n < 200) begin
      n++;
      @(negedge i_clk);
    end
    checks++;
    if (n !== 35) begin
      failures++;
      $display("FAIL tick_busy_len got=%0d exp=35", n);
    end
    checks++;
    if (mq.size() - base !== 34 + OFF) begin
      failures++;
      $display("FAIL tick_nbytes got=%0d exp=%0d",
               mq.size() - base, 34 + OFF);
    end
`ifdef LCD_REFRESH_INIT_SEQ_EN
    checks++;
    if (mq.size() < base + 4 ||
        {mq[base], mq[base+1], mq[base+2], mq[base+3]}
        !== {9'h038, 9'h00C, 9'h006, 9'h001}) begin
      failures++;
      $display("FAIL init_seq got=%h exp=0380..001",
               mq.size() >= base + 4 ? mq[base] : 9'h1FF);
    end
`endif
    bad = frame_bad(L1_25, L2_60, base + OFF);
    checks++;
    if (bad !== -1) begin
      failures++;
      $display("FAIL tick_bytes first bad idx=%0d exp=-1", bad);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL tick_done got=%0d exp=1", done_cnt - d0);
    end
  endtask

  task automatic test_update;
    int base, d0, n, bad;
    base = mq.size();
    d0 = done_cnt;
    wait_en(139);
    pulse_update();
    checks++;
    if ({o_busy, o_lcd_valid, o_lcd_rs, o_lcd_data}
        !== 11'b110_1000_0000) begin
      failures++;
      $display("FAIL upd_start got=%b exp=11010000000",
               {o_busy, o_lcd_valid, o_lcd_rs, o_lcd_data});
    end
    n = 0;
    while (o_busy && n < 200) begin
      n++;
      @(negedge i_clk);
    end
    checks++;
    if (n !== 35) begin
      failures++;
      $display("FAIL upd_busy_len got=%0d exp=35", n);
    end
    bad = frame_bad(L1_25, L2_60, base);
    checks++;
    if (bad !== -1 || mq.size() - base !== 34) begin
      failures++;
      $display("FAIL upd_bytes bad=%0d n=%0d exp=-1/34",
               bad, mq.size() - base);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL upd_done got=%0d exp=1", done_cnt - d0);
    end
  endtask

  task automatic test_snapshot;
    int base, bad;
    base = mq.size();
    wait_en(201);
    i_line1 = L1_30;
    wait_en(236);
    bad = frame_bad(L1_25, L2_60, base);
    checks++;
    if (bad !== -1 || mq.size() - base !== 34) begin
      failures++;
      $display("FAIL snap_old bad=%0d n=%0d exp=-1/34",
               bad, mq.size() - base);
    end
    base = mq.size();
    wait_en(239);
    pulse_update();
    wait_en(278);
    bad = frame_bad(L1_30, L2_60, base);
    checks++;
    if (bad !== -1 || mq.size() - base !== 34) begin
      failures++;
      $display("FAIL snap_new bad=%0d n=%0d exp=-1/34",
               bad, mq.size() - base);
    end
  endtask

  task automatic test_random_ready;
    int base, d0, bad, viol, stalls;
    logic seen, pv, pr;
    logic [9:0] prev;
    base = mq.size();
    d0 = done_cnt;
    viol = 0;
    stalls = 0;
    seen = 1'b0;
    pv = 1'b0;
    pr = 1'b1;
    prev = '0;
    wait_en(295);
    for (int k = 0; k < 300; k++) begin
      if (pv && !pr) begin
        stalls++;
        if ({o_lcd_valid, o_lcd_rs, o_lcd_data} !== prev)
          viol++;
      end
      pv = o_lcd_valid;
      pr = i_lcd_ready;
      prev = {o_lcd_valid, o_lcd_rs, o_lcd_data};
      if (o_busy) seen = 1'b1;
      if (seen && !o_busy) break;
      @(posedge i_clk);
      #1;
      if (en < 360) i_lcd_ready = 1'($urandom_range(0, 1));
      else          i_lcd_ready = 1'b1;
      @(negedge i_clk);
    end
    i_lcd_ready = 1'b1;
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL rnd_stable viol=%0d exp=0", viol);
    end
    checks++;
    if (stalls == 0) begin
      failures++;
      $display("FAIL rnd_stalls got=0 exp=>0");
    end
    bad = frame_bad(L1_30, L2_60, base);
    checks++;
    if (bad !== -1 || mq.size() - base !== 34) begin
      failures++;
      $display("FAIL rnd_bytes bad=%0d n=%0d exp=-1/34",
               bad, mq.size() - base);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL rnd_done got=%0d exp=1", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back;
    int base, d0, b1, b2;
    wait_en(470);
    base = mq.size();
    d0 = done_cnt;
    wait_en(479);
    pulse_update();
    wait_en(484);
    pulse_update();
    wait_en(489);
    pulse_update();
    wait_en(515);
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap busy=%b exp=0", o_busy);
    end
    @(negedge i_clk);
    checks++;
    if ({o_busy, o_lcd_valid, o_lcd_data} !== 10'b11_1000_0000) begin
      failures++;
      $display("FAIL b2b_restart got=%b exp=1110000000",
               {o_busy, o_lcd_valid, o_lcd_data});
    end
    wait_en(590);
    checks++;
    if (done_cnt - d0 !== 2) begin
      failures++;
      $display("FAIL b2b_frames got=%0d exp=2", done_cnt - d0);
    end
    b1 = frame_bad(L1_30, L2_60, base);
    b2 = frame_bad(L1_30, L2_60, base + 34);
    checks++;
    if (b1 !== -1 || b2 !== -1 || mq.size() - base !== 68) begin
      failures++;
      $display("FAIL b2b_bytes b1=%0d b2=%0d n=%0d exp=-1/-1/68",
               b1, b2, mq.size() - base);
    end
  endtask

  task automatic test_reset_mid;
    int base, d0;
    wait_en(649);
    pulse_update();
    wait_en(656);
    checks++;
    if ({o_lcd_valid, o_lcd_rs, o_lcd_data} !== 10'b11_0011_0011) begin
      failures++;
      $display("FAIL mid_col5 got=%h exp=333",
               {o_lcd_valid, o_lcd_rs, o_lcd_data});
    end
    i_rst_n = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_lcd_valid, o_lcd_rs, o_lcd_data, o_busy, o_frame_done}
        !== 12'h0) begin
      failures++;
      $display("FAIL abort_outputs got=%h exp=0",
               {o_lcd_valid, o_lcd_rs, o_lcd_data, o_busy, o_frame_done});
    end
    base = mq.size();
    d0 = done_cnt;
    i_rst_n = 1'b1;
    repeat (20) @(negedge i_clk);
    checks++;
    if (done_cnt !== d0) begin
      failures++;
      $display("FAIL abort_done got=%0d exp=0", done_cnt - d0);
    end
    checks++;
    if (mq.size() - base !== OFF) begin
      failures++;
      $display("FAIL abort_bytes got=%0d exp=%0d",
               mq.size() - base, OFF);
    end
  endtask

  initial begin
    test_reset();
    test_tick_frame();
    test_update();
    test_snapshot();
    test_random_ready();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_refresh_ctrl.md
Name: lcd_refresh_ctrl

Overview:
- Schedules and sequences writes of the two 16-character ASCII display lines (temperature and humidity text) into a character-LCD byte interface.
- Sits between the temperature/humidity display top (which supplies `i_line1`/`i_line2`) and the LCD bus driver (which accepts one byte per valid/ready handshake).
- Starts a frame on either a periodic refresh tick or an explicit update request.
- Snapshots both lines at frame start so the displayed text never tears.

Parameters:
- REFRESH_CYCLES, 5_000_000: clock cycles between periodic refresh ticks (100 ms at 50 MHz); must be >= 2.
- COLS, 16: characters per line. The port widths are COLS*8.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_line1  in  COLS*8  line-1 ASCII; bits [COLS*8-1 -: 8] = column 0.
- i_line2  in  COLS*8  line-2 ASCII, same ordering.
- i_update  in  1  one-cycle request for an immediate frame.
- o_lcd_valid  out  1  byte on o_lcd_data/o_lcd_rs is valid.
- o_lcd_rs  out  1  0 = command byte, 1 = character byte.
- o_lcd_data  out  8  byte to LCD driver.
- i_lcd_ready  in  1  driver accepts the byte when o_lcd_valid & i_lcd_ready.
- o_busy  out  1  a frame is in progress.
- o_frame_done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - All outputs go to 0; FSM goes to IDLE; pending flag, char index and refresh counter clear.
  - Reset asserted mid-frame aborts the frame immediately. No further bytes are issued and no o_frame_done pulse is produced.
- Refresh counter:
  - Counts 0..REFRESH_CYCLES-1 and wraps; tick = (count == REFRESH_CYCLES-1).
  - Free-running, including while busy.
- Trigger = tick | i_update | pending.
  - A trigger arriving while busy sets pending (single-deep; further triggers coalesce).
  - pending clears when the next frame starts.
- FSM states: IDLE, CMD1, DATA1, CMD2, DATA2, DONE.
  - IDLE: on trigger at edge n, latch i_line1/i_line2 into snapshot registers. Go to CMD1 with o_busy=1, o_lcd_valid=1, rs=0, data=0x80 from cycle n+1.
  - CMD1: on accept, go to DATA1 with idx=0.
  - DATA1: present snapshot1 column idx with rs=1. On accept, idx++. After column COLS-1 is accepted, go to CMD2.
  - CMD2: present rs=0, data=0xC0. On accept, go to DATA2 with idx=0.
  - DATA2: same as DATA1 using snapshot2. After the last column is accepted, go to DONE.
  - DONE: for one cycle, o_lcd_valid=0, o_frame_done=1 and o_busy still 1. Next cycle, return to IDLE with o_busy=0.
  - From IDLE, pending (or a same-cycle trigger) starts the next frame.
- Handshake rules:
  - o_lcd_valid, o_lcd_rs and o_lcd_data are registered.
  - They stay stable while o_lcd_valid=1 and i_lcd_ready=0.
  - There is no idle bubble between consecutive bytes; the next byte is presented the cycle after an accept.
  - A frame is COLS*2+2 = 34 transfers. With i_lcd_ready tied high, a frame spans 35 cycles of o_busy (34 transfers plus DONE).
- Snapshot: changes on i_line1/i_line2 during a frame do not affect that frame.
- Simultaneous tick and i_update in IDLE: a single frame starts and pending is not set.
- idx width is $clog2(COLS). It must not exceed COLS-1.

Optional Feature:
- Macro: LCD_REFRESH_INIT_SEQ_EN.
- Defined: after reset, before the first frame, the FSM passes through INIT and emits command bytes 0x38, 0x0C, 0x06, 0x01 (rs=0, same handshake) with o_busy=1 and no o_frame_done pulse.
  - Triggers during INIT set pending.
  - INIT runs once per reset.
- Undefined: the INIT state and its ROM are absent; the first trigger goes directly to CMD1.

Decomposition:
- Package lcd_pkg:
  - Command constants LCD_CMD_LINE1=8'h80, LCD_CMD_LINE2=8'hC0 and the init command list.
  - State enum.
  - ASCII space constant 8'h20.
- Sub-module refresh_tick_gen (parameter REFRESH_CYCLES; ports i_clk, i_rst_n, o_tick) holds the refresh counter.

Test Plan:
- Reset with REFRESH_CYCLES=100, i_lcd_ready=1 held: all outputs are 0; the first frame starts at the tick (count 99) and emits 0x80, "TEMP=25 C      ", 0xC0, "HUM =60 %      ", then one o_frame_done pulse.
- i_update pulse in IDLE at edge n: o_lcd_valid=1 with data 0x80 and rs=0 from cycle n+1; o_busy lasts 35 cycles.
- i_lcd_ready toggled randomly (about 50%) across a frame: each byte is held stable until accepted; 34 accepted bytes in the correct order.
- Change i_line1 to "TEMP=30 C" mid-frame: the current frame still sends "25". The next frame sends "30".
- Two i_update pulses and one tick during a frame: exactly one extra frame follows immediately after DONE.
- Assert i_rst_n=0 during DATA1 at column 5: outputs are 0 next cycle and no o_frame_done pulse occurs. With LCD_REFRESH_INIT_SEQ_EN, 0x38, 0x0C, 0x06, 0x01 precede the first 0x80 after reset.
